// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch/sequencing stage feeding the control FSM
//
// Owns the program counter, reads 9-bit words from a synchronous-read
// instruction memory, presents ir/din and a one-cycle Run pulse, then waits
// for done (with optional jmp) before fetching the next instruction.
//
// Optional feature macro: IFETCH_WATCHDOG_EN
//   defined   -> EXEC is bounded by WDOG_CYC cycles; expiry sets err and halts
//   undefined -> no counter, err tied 0, EXEC waits indefinitely
//
// Ports:
//   clk       in   1       clock, rising edge
//   Resetn    in   1       asynchronous, active-high reset
//   en        in   1       fetch enable, sampled only in FETCH
//   mem_addr  out  ADDR_W  instruction memory address
//   mem_rd    out  1       memory read strobe
//   mem_data  in   9       memory read data, valid the cycle after the read is issued
//   done      in   1       instruction-complete from the control FSM
//   jmp       in   1       jump-taken, qualified by done
//   ir        out  9       instruction register ([8:6] op, [5:3] rx, [2:0] ry)
//   din       out  9       immediate word for MVI/JMP
//   Run       out  1       one-cycle start pulse to the control FSM
//   pc        out  ADDR_W  current program counter
//   halted    out  1       illegal opcode or watchdog expiry; fetch stopped
//   err       out  1       watchdog expiry

module ifetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                WDOG_CYC = 8
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [8:0]        mem_data,
    input  logic              done,
    input  logic              jmp,
    output logic [8:0]        ir,
    output logic [8:0]        din,
    output logic              Run,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH,
        S_IMM,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [8:0]        r_ir;
    logic [8:0]        r_din;
    logic              r_run;
    logic              r_halted;

    logic [2:0]        w_opcode;
    logic              w_two_word;
    logic              w_illegal;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_opcode   = mem_data[8:6];
    // MVI (011) and JMP (100) carry an immediate word
    assign w_two_word = (w_opcode == 3'b011) || (w_opcode == 3'b100);
    // 101, 110, 111 are unassigned opcodes
    assign w_illegal  = w_opcode[2] & (w_opcode[1] | w_opcode[0]);
    // natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap
    assign w_pc_inc   = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef IFETCH_WATCHDOG_EN
    localparam int WD_W = ($clog2(WDOG_CYC) > 0) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_err;
`endif

    always_ff @(posedge clk or posedge Resetn) begin
        if (Resetn) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_ir       <= '0;
            r_din      <= '0;
            r_run      <= 1'b0;
            r_halted   <= 1'b0;
`ifdef IFETCH_WATCHDOG_EN
            r_wdog     <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (en) begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_state    <= S_LATCH;
                    end else begin
                        r_mem_rd   <= 1'b0;
                    end
                end

                S_LATCH: begin
                    r_ir <= mem_data;
                    r_pc <= w_pc_inc;
                    if (w_illegal) begin
                        r_mem_rd <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_two_word) begin
                        // immediate sits at the word after the opcode
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_pc_inc;
                        r_state    <= S_IMM;
                    end else begin
                        r_mem_rd <= 1'b0;
                        r_run    <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end

                S_IMM: begin
                    r_din    <= mem_data;
                    r_pc     <= w_pc_inc;
                    r_mem_rd <= 1'b0;
                    r_run    <= 1'b1;
                    r_state  <= S_ISSUE;
                end

                S_ISSUE: begin
                    r_run   <= 1'b0;
                    r_state <= S_EXEC;
`ifdef IFETCH_WATCHDOG_EN
                    r_wdog  <= '0;
`endif
                end

                S_EXEC: begin
                    // done is checked first so completion on the limit cycle wins
                    if (done) begin
                        if (jmp) begin
                            r_pc <= r_din[ADDR_W-1:0];
                        end
                        r_state <= S_FETCH;
                    end
`ifdef IFETCH_WATCHDOG_EN
                    else if (r_wdog == WD_LAST) begin
                        r_err    <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end

                S_HALT: begin
                    // terminal until reset
                    r_mem_rd <= 1'b0;
                    r_run    <= 1'b0;
                    r_halted <= 1'b1;
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign ir       = r_ir;
    assign din      = r_din;
    assign Run      = r_run;
    assign pc       = r_pc;
    assign halted   = r_halted;

`ifdef IFETCH_WATCHDOG_EN
    assign err = r_err;
`else
    // no watchdog: err can never fire (a negative limit is never meaningful)
    assign err = (WDOG_CYC < 0);
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit

module tb_ifetch_unit;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              done = 1'b0;
    logic              jmp = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [8:0]        mem_data;
    logic [8:0]        ir;
    logic [8:0]        din;
    logic              Run;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              err;

    logic [8:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    logic seen_run;
    logic seen_rd;

    always #5 clk = ~clk;

    // synchronous-read memory: the registered address from the DUT selects
    // the word that is presented during the following cycle
    assign mem_data = mem[mem_addr];

    ifetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (8'h00),
        .WDOG_CYC (8)
    ) dut (
        .clk      (clk),
        .Resetn   (rst),
        .en       (en),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .done     (done),
        .jmp      (jmp),
        .ir       (ir),
        .din      (din),
        .Run      (Run),
        .pc       (pc),
        .halted   (halted),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst  = 1'b1;
        done = 1'b0;
        jmp  = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic finish_instr(input logic j);
        done = 1'b1;
        jmp  = j;
        step();
        done = 1'b0;
        jmp  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'h000;
        en = 1'b1;
        #2;
        check("rst_pc",     pc,       0);
        check("rst_addr",   mem_addr, 0);
        check("rst_rd",     mem_rd,   0);
        check("rst_ir",     ir,       0);
        check("rst_din",    din,      0);
        check("rst_run",    Run,      0);
        check("rst_halted", halted,   0);
        check("rst_err",    err,      0);

        // ADD R1,R2: Run on the third cycle, pc advances by one
        mem[0] = 9'h00A;
        release_reset();
        step();
        check("add_rd",     mem_rd,   1);
        check("add_addr",   mem_addr, 0);
        check("add_run_lo", Run,      0);
        step();
        check("add_run",    Run,      1);
        check("add_ir",     ir,       9'h00A);
        check("add_pc_lat", pc,       1);
        step();
        step();
        step();
        check("add_run_once", Run,    0);
        finish_instr(1'b0);
        check("add_pc_done", pc,      1);
        step();
        check("add_next_addr", mem_addr, 1);
        check("add_next_rd",   mem_rd,   1);

        // MVI R3 with immediate 0x055; done held high outside EXEC is ignored
        hold_reset();
        mem[0] = 9'h0D8;
        mem[1] = 9'h055;
        release_reset();
        done = 1'b1;
        step();
        check("mvi_addr0", mem_addr, 0);
        step();
        check("mvi_addr1", mem_addr, 1);
        check("mvi_rd1",   mem_rd,   1);
        check("mvi_ir",    ir,       9'h0D8);
        check("mvi_run_lo", Run,     0);
        step();
        check("mvi_run",   Run,      1);
        check("mvi_din",   din,      9'h055);
        check("mvi_pc",    pc,       2);
        done = 1'b0;
        step();
        finish_instr(1'b0);
        check("mvi_pc_done", pc,     2);

        // JMP to 4, then JMP 0x1F0 whose upper din bit is dropped
        hold_reset();
        mem[0] = 9'h100;
        mem[1] = 9'h004;
        mem[4] = 9'h100;
        mem[5] = 9'h1F0;
        release_reset();
        repeat (4) step();
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        check("jmp_nodone_pc", pc,   2);
        finish_instr(1'b1);
        check("jmp1_pc",   pc,       4);
        step();
        check("jmp2_addr", mem_addr, 4);
        repeat (3) step();
        check("jmp2_din",  din,      9'h1F0);
        finish_instr(1'b1);
        check("jmp2_pc",   pc,       8'hF0);
        step();
        check("jmp2_fetch_addr", mem_addr, 8'hF0);
        check("jmp2_fetch_rd",   mem_rd,   1);

        // MVI at 0xFF: immediate fetched from wrapped address 0
        hold_reset();
        mem[0]     = 9'h100;
        mem[1]     = 9'h0FF;
        mem[8'hFF] = 9'h0D8;
        release_reset();
        repeat (4) step();
        finish_instr(1'b1);
        check("wrap_pc_ff",  pc,       8'hFF);
        step();
        check("wrap_addr_ff", mem_addr, 8'hFF);
        step();
        check("wrap_imm_addr", mem_addr, 8'h00);
        check("wrap_pc0",    pc,       8'h00);
        step();
        check("wrap_din",    din,      9'h100);
        check("wrap_run",    Run,      1);
        step();
        finish_instr(1'b0);
        check("wrap_pc_done", pc,      8'h01);

        // illegal opcode halts two cycles after reset with no Run
        hold_reset();
        mem[0] = 9'h1C0;
        release_reset();
        step();
        check("ill_halt_lo", halted,   0);
        step();
        check("ill_halted",  halted,   1);
        check("ill_rd",      mem_rd,   0);
        seen_run = Run;
        seen_rd  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_run = seen_run | Run;
            seen_rd  = seen_rd | mem_rd;
        end
        check("ill_no_run",  seen_run, 0);
        check("ill_no_rd",   seen_rd,  0);

        // en low from reset: no fetch; en only matters in FETCH
        hold_reset();
        mem[0] = 9'h00A;
        en = 1'b0;
        release_reset();
        seen_rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen_rd = seen_rd | mem_rd;
        end
        check("en0_no_rd",   seen_rd,  0);
        check("en0_pc",      pc,       0);
        en = 1'b1;
        step();
        check("en1_rd",      mem_rd,   1);
        en = 1'b0;
        step();
        check("en_mid_run",  Run,      1);
        en = 1'b1;

        // asynchronous reset in the middle of EXEC
        hold_reset();
        mem[0] = 9'h0D8;
        mem[1] = 9'h055;
        release_reset();
        repeat (6) step();
        check("ar_pre_pc",   pc,       2);
        check("ar_pre_din",  din,      9'h055);
        #2;
        rst = 1'b1;
        #1;
        check("ar_pc",       pc,       0);
        check("ar_run",      Run,      0);
        check("ar_ir",       ir,       0);
        check("ar_din",      din,      0);
        check("ar_addr",     mem_addr, 0);
        check("ar_rd",       mem_rd,   0);

        // EXEC without done
        hold_reset();
        mem[0] = 9'h00A;
        release_reset();
        repeat (3) step();
`ifdef IFETCH_WATCHDOG_EN
        repeat (7) step();
        check("wd_err_lo",    err,     0);
        check("wd_halt_lo",   halted,  0);
        step();
        check("wd_err",       err,     1);
        check("wd_halted",    halted,  1);
        hold_reset();
        mem[0] = 9'h00A;
        release_reset();
        repeat (10) step();
        finish_instr(1'b0);
        check("wd_done_wins_err", err, 0);
        check("wd_done_wins_pc",  pc,  1);
`else
        repeat (20) step();
        check("nowd_err",     err,     0);
        check("nowd_halted",  halted,  0);
        check("nowd_run",     Run,     0);
        finish_instr(1'b0);
        check("nowd_pc",      pc,      1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch/sequencing stage directly upstream of the control-unit FSM.
- Owns the program counter and reads 9-bit words from a synchronous-read instruction memory.
- Presents `ir` and a one-cycle `Run` pulse, and supplies the immediate word (`din`) for MVI/JMP.
- Waits for `done` from the FSM; on `done` with `jmp`, loads PC from the immediate.

Parameters:
- ADDR_W, 8, instruction memory address / PC width.
- RESET_PC, 0, PC value after reset.
- WDOG_CYC, 8, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- Resetn  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable; when 0, no new fetch starts.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_rd  out  1  memory read strobe; data returns one cycle later.
- mem_data  in  9  memory read data, valid the cycle after mem_rd.
- done  in  1  instruction-complete from the control FSM.
- jmp  in  1  jump-taken from the control FSM, qualified by done.
- ir  out  9  instruction register; [8:6] opcode, [5:3] rx, [2:0] ry.
- din  out  9  immediate word for MVI/JMP.
- Run  out  1  one-cycle start pulse to the control FSM.
- pc  out  ADDR_W  current program counter.
- halted  out  1  illegal opcode seen; fetch stopped.
- err  out  1  watchdog expiry (optional feature).

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, ir=0, din=0, Run=0, mem_rd=0, mem_addr=0, halted=0, err=0.
- Outputs are registered. ir and din hold their values until the next LATCH/IMM write.
- Opcode classes:
  - 000 ADD, 001 SUB, 010 MV: 1 word.
  - 011 MVI, 100 JMP: 2 words (immediate follows).
  - 101..111: illegal.
- FETCH: if en, mem_rd=1, mem_addr=pc, go to LATCH. Else stay, mem_rd=0.
- LATCH: ir<=mem_data, pc<=pc+1.
  - 2-word opcode: mem_rd=1, mem_addr=pc+1, go to IMM.
  - Illegal opcode: go to HALT.
  - Otherwise: go to ISSUE.
- IMM: din<=mem_data, pc<=pc+1, go to ISSUE.
- ISSUE: Run=1 for exactly this cycle, go to EXEC.
- EXEC: Run=0. Wait for done=1.
  - On done: if jmp, pc<=din[ADDR_W-1:0]; else pc unchanged. Go to FETCH.
  - done in any state other than EXEC is ignored.
- HALT: halted=1, mem_rd=0. Leave only via reset.
- Latency: 1-word instruction = 3 cycles FETCH to Run; 2-word instruction = 4 cycles.
- PC arithmetic is modulo 2^ADDR_W. pc=2^ADDR_W-1 wraps to 0, including the immediate fetch at wrap.
- JMP target uses the low ADDR_W bits of din; din upper bits are ignored.
- en deasserted mid-instruction has no effect. en is sampled only in FETCH.
- Reset mid-EXEC aborts immediately: Run=0, pc=RESET_PC.
- Run is never asserted twice without an intervening done.

Optional Feature:
- Macro: IFETCH_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to EXEC and increments each EXEC cycle without done.
  - On reaching WDOG_CYC: err<=1, go to HALT with halted=1.
  - done in the same cycle the limit is reached wins (normal completion, no err).
- Not defined: no counter; err tied 0; EXEC waits indefinitely.

Test Plan:
- Reset with mem[0]=9'b000_001_010 (ADD R1,R2), en=1, done returned 3 cycles after Run -> Run pulses at cycle 3; ir=0x00A; pc=1 after done; next mem_addr=1.
- mem[0]=011_011_000 (MVI R3), mem[1]=0x055 -> mem_addr sequence 0,1; din=0x055; Run at cycle 4; pc=2 after done.
- mem[4]=100_000_000 (JMP), mem[5]=0x1F0, pc=4, done+jmp -> pc=0xF0; next fetch mem_addr=0xF0.
- pc=0xFF holding MVI, immediate at 0x00 -> immediate read from addr 0; pc=0x01 after done.
- mem[0]=9'b111_000_000 -> halted=1 two cycles after reset; no Run; mem_rd stays 0. en=0 from reset -> mem_rd never asserts.
- Watchdog on (IFETCH_WATCHDOG_EN), done withheld -> err=1 and halted=1 after 8 EXEC cycles. Async reset asserted mid-EXEC -> all outputs at reset values without a clock edge.
